sb_rx_deserializer: RTL and testbench

SB_RX_DESERIALIZER -- requirements
Module: sb_rx_deserializer

---
 rtl/sb_pkg.sv | 20 ++
 rtl/sb_rx_pkt_fifo.sv | 59 +++++
 rtl/sb_rx_deserializer.sv | 172 +++++++++++++++++
 tb/tb_sb_rx_deserializer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared sideband definitions.
// Holds the receive-FSM state encoding and the default link constants
// (minimum inter-packet gap and the init pattern word) used by the
// sideband blocks.
package sb_pkg;

  // Default minimum idle UI between two packets.
  localparam int SB_GAP_MIN_DEFAULT = 32;

  // Default sideband init pattern; bit 0 is the first bit on the wire.
  localparam logic [63:0] SB_PATTERN_DEFAULT = 64'h5555_5555_5555_5555;

  // Receive FSM state encoding.
  typedef logic [1:0] sb_rx_state_t;
  localparam sb_rx_state_t ST_IDLE    = 2'd0;
  localparam sb_rx_state_t ST_SHIFT   = 2'd1;
  localparam sb_rx_state_t ST_GAP     = 2'd2;
  localparam sb_rx_state_t ST_DISCARD = 2'd3;

endpackage

// File: rtl/sb_rx_pkt_fifo.sv
// Packet buffer for the sideband receiver.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data (dropped if full and no pop this cycle)
//   push_data  - word to write
//   pop        - remove the head entry (ignored when empty)
//   head       - head entry, 0 when empty
//   valid      - buffer non-empty
//   full       - buffer holds DEPTH entries
// DEPTH must be a power of two, at least 2: pointers carry one extra wrap
// bit above the index bits so full and empty can be told apart.
module sb_rx_pkt_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign valid = (wr_ptr != rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full buffer
  // is accepted when the head is leaving.
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  assign head = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sb_rx_deserializer.sv
// Sideband receive deserializer.
// Collects 64 serial bits (LSB first) into a word, enforces a minimum idle
// gap between packets, filters/detects the init pattern and buffers
// completed words for the consumer.
// Ports:
//   i_clk, i_rst        - bit clock (one UI per cycle), async active-high reset
//   i_rx_active         - a valid sideband bit is present this cycle
//   i_rxdatasb          - serial data bit
//   i_pattern_det_en    - enable pattern detection / filtering
//   i_ready             - consumer accepts the head packet
//   o_packet, o_valid   - head packet and buffer non-empty
//   o_pattern_detected  - two consecutive pattern words seen (level)
//   o_frame_err         - pulse: packet truncated
//   o_gap_err           - pulse: packet started before the gap elapsed
//   o_overflow          - pulse: completed word dropped, buffer full
// Handshake: a packet transfers on every cycle where o_valid and i_ready
// are both high; o_packet is stable while o_valid is high and i_ready low.
module sb_rx_deserializer
  import sb_pkg::*;
#(
  parameter int          GAP_MIN = SB_GAP_MIN_DEFAULT,
  parameter int          DEPTH   = 2,
  parameter logic [63:0] PATTERN = SB_PATTERN_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_active,
  input  logic        i_rxdatasb,
  input  logic        i_pattern_det_en,
  input  logic        i_ready,
  output logic [63:0] o_packet,
  output logic        o_valid,
  output logic        o_pattern_detected,
  output logic        o_frame_err,
  output logic        o_gap_err,
  output logic        o_overflow
);

  localparam int                 GAP_W     = $clog2(GAP_MIN + 1);
  localparam logic [GAP_W-1:0]   GAP_LIMIT = GAP_W'(GAP_MIN);
  localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);

  sb_rx_state_t     state;
  logic [6:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [63:0]      shift_reg;
  logic [1:0]       pat_cnt;
  logic             frame_err_q;
  logic             gap_err_q;
  logic             overflow_q;

  logic             word_done;
  logic [63:0]      full_word;
  logic             is_pattern;
  logic             push;
  logic             pop;
  logic             frame_evt;
  logic             gap_evt;
  logic [GAP_W-1:0] gap_next;
  logic             fifo_full;
  logic             fifo_valid;
  logic [63:0]      fifo_head;

  // The 64th bit is merged combinationally so the word is written into the
  // buffer on the same edge that captures that bit.
  assign word_done  = (state == ST_SHIFT) && i_rx_active && (bit_cnt == 7'd63);
  assign full_word  = {i_rxdatasb, shift_reg[62:0]};
  assign is_pattern = i_pattern_det_en && (full_word == PATTERN);
  assign push       = word_done && !is_pattern;
  assign frame_evt  = (state == ST_SHIFT) && !i_rx_active;
  // Every cycle in GAP has gap_cnt below GAP_MIN, so any activity is early.
  assign gap_evt    = (state == ST_GAP) && i_rx_active;
  assign gap_next   = (gap_cnt == GAP_LIMIT) ? gap_cnt : gap_cnt + 1'b1;
  assign pop        = fifo_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_rx_active) begin
            shift_reg <= {63'd0, i_rxdatasb};
            bit_cnt   <= 7'd1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (i_rx_active) begin
            shift_reg[bit_cnt[5:0]] <= i_rxdatasb;
            bit_cnt                 <= bit_cnt + 7'd1;
            if (bit_cnt == 7'd63) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end else begin
            // Truncated packet: this idle cycle already counts toward the gap.
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= GAP_ONE;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (i_rx_active) begin
            state <= ST_DISCARD;
          end else begin
            gap_cnt <= gap_next;
            if (gap_next >= GAP_LIMIT) state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (!i_rx_active) begin
            gap_cnt <= GAP_ONE;
            state   <= ST_GAP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pattern counter saturates at 2 so the detect level holds while further
  // pattern words keep arriving.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pat_cnt <= '0;
    end else if (!i_pattern_det_en || frame_evt || gap_evt) begin
      pat_cnt <= '0;
    end else if (word_done) begin
      if (!is_pattern)         pat_cnt <= '0;
      else if (pat_cnt != 2'd2) pat_cnt <= pat_cnt + 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_err_q <= 1'b0;
      gap_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= frame_evt;
      gap_err_q   <= gap_evt;
      overflow_q  <= push && fifo_full && !pop;
    end
  end

  sb_rx_pkt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (full_word),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign o_packet           = fifo_head;
  assign o_valid            = fifo_valid;
  assign o_pattern_detected = (pat_cnt == 2'd2) && i_pattern_det_en;
  assign o_frame_err        = frame_err_q;
  assign o_gap_err          = gap_err_q;
  assign o_overflow         = overflow_q;

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Bench for sb_rx_deserializer: scenario tasks drive serial packets; every
// consumed packet is checked against an expected queue.
module tb_sb_rx_deserializer;

  localparam logic [63:0] PAT = 64'h5555_5555_5555_5555;

  logic        clk;
  logic        rst;
  logic        rx_active;
  logic        rxdatasb;
  logic        pattern_det_en;
  logic        ready;
  logic [63:0] packet;
  logic        valid;
  logic        pattern_detected;
  logic        frame_err;
  logic        gap_err;
  logic        overflow;

  int total;
  int bad;
  int frame_seen;
  int gap_seen;
  int ovf_seen;

  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_rx_deserializer #(
    .GAP_MIN (32),
    .DEPTH   (2),
    .PATTERN (PAT)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_rx_active        (rx_active),
    .i_rxdatasb         (rxdatasb),
    .i_pattern_det_en   (pattern_det_en),
    .i_ready            (ready),
    .o_packet           (packet),
    .o_valid            (valid),
    .o_pattern_detected (pattern_detected),
    .o_frame_err        (frame_err),
    .o_gap_err          (gap_err),
    .o_overflow         (overflow)
  );

  // ---------------- driver tasks ----------------
  // One UI: inputs driven just after a rising edge, outputs observed on the
  // falling edge (pulses counted, transfers scored), then the next rising edge.
  task automatic tick(input logic act, input logic d);
    logic [63:0] exp;
    rx_active = act;
    rxdatasb  = d;
    @(negedge clk);
    if (frame_err) frame_seen++;
    if (gap_err)   gap_seen++;
    if (overflow)  ovf_seen++;
    if (valid && ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_packet: got %h, required none", packet);
      end else begin
        exp = exp_q.pop_front();
        if (packet !== exp) begin
          bad++;
          $display("FAIL packet_data: got %h, required %h", packet, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [63:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) tick(1'b1, w[i]);
  endtask

  task automatic send_word(input logic [63:0] w, input logic expect_push);
    if (expect_push) exp_q.push_back(w);
    send_bits(w, 64);
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    if (w == PAT) w = ~w;
    return w;
  endfunction

  task automatic clear_counts();
    frame_seen = 0;
    gap_seen   = 0;
    ovf_seen   = 0;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({packet, valid, pattern_detected, frame_err, gap_err, overflow} !== 69'd0) begin
      bad++;
      $display("FAIL %s: packet=%h valid=%b pat=%b ferr=%b gerr=%b ovf=%b, required all 0",
               name, packet, valid, pattern_detected, frame_err, gap_err, overflow);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      ready = 1'b0;
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    tick(1'b0, 1'b0);
    check_outputs_zero("after_reset_outputs");
  endtask

  task automatic test_basic();
    logic [63:0] w;
    clear_counts();
    w = 64'h0000_0000_0000_A5C3;
    ready = 1'b0;
    exp_q.push_back(w);
    send_bits(w, 63);
    check_int("valid_before_last_bit", int'(valid), 0);
    tick(1'b1, w[63]);
    check_int("valid_one_cycle_after", int'(valid), 1);
    total++;
    if (packet !== 64'h0000_0000_0000_A5C3) begin
      bad++;
      $display("FAIL basic_head: got %h, required %h", packet, 64'h0000_0000_0000_A5C3);
    end
    ready = 1'b1;
    idle(32);
    check_int("basic_frame_err", frame_seen, 0);
    check_int("basic_gap_err", gap_seen, 0);
    check_int("basic_drained", exp_q.size(), 0);
    check_int("basic_valid_low", int'(valid), 0);
  endtask

  task automatic test_gap_err();
    clear_counts();
    ready = 1'b1;
    send_word(rand_word(), 1'b1);
    idle(10);
    send_word(rand_word(), 1'b0);
    idle(32);
    check_int("gap_err_pulses", gap_seen, 1);
    send_word(rand_word(), 1'b1);
    idle(32);
    check_int("gap_err_after_recovery", gap_seen, 1);
    check_int("gap_frame_err", frame_seen, 0);
    check_int("gap_drained", exp_q.size(), 0);
  endtask

  task automatic test_frame_err();
    clear_counts();
    ready = 1'b1;
    send_bits(rand_word(), 40);
    idle(32);
    check_int("frame_err_pulses", frame_seen, 1);
    check_int("frame_no_push", int'(valid), 0);
    send_word(rand_word(), 1'b1);
    idle(32);
    check_int("frame_err_after_recovery", frame_seen, 1);
    check_int("frame_drained", exp_q.size(), 0);
  endtask

  task automatic test_pattern();
    clear_counts();
    ready = 1'b1;
    pattern_det_en = 1'b1;
    send_word(PAT, 1'b0);
    check_int("pattern_after_first", int'(pattern_detected), 0);
    idle(32);
    send_word(PAT, 1'b0);
    check_int("pattern_after_second", int'(pattern_detected), 1);
    check_int("pattern_not_pushed", int'(valid), 0);
    idle(32);
    check_int("pattern_level_holds", int'(pattern_detected), 1);
    pattern_det_en = 1'b0;
    tick(1'b0, 1'b0);
    pattern_det_en = 1'b1;
    check_int("pattern_cleared_by_en", int'(pattern_detected), 0);
    pattern_det_en = 1'b0;
    // With detection off the pattern word is ordinary data.
    send_word(PAT, 1'b1);
    idle(32);
    check_int("pattern_passthrough_drained", exp_q.size(), 0);
  endtask

  task automatic test_overflow();
    logic [63:0] p1;
    logic [63:0] p2;
    clear_counts();
    ready = 1'b0;
    p1 = rand_word();
    p2 = rand_word();
    send_word(p1, 1'b1);
    idle(32);
    send_word(p2, 1'b1);
    idle(32);
    check_int("ovf_none_yet", ovf_seen, 0);
    send_word(rand_word(), 1'b0);
    idle(32);
    check_int("ovf_pulses", ovf_seen, 1);
    check_int("ovf_valid", int'(valid), 1);
    total++;
    if (packet !== p1) begin
      bad++;
      $display("FAIL ovf_head: got %h, required %h", packet, p1);
    end
    ready = 1'b1;
    idle(3);
    check_int("ovf_drained", exp_q.size(), 0);
    check_int("ovf_valid_low", int'(valid), 0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    clear_counts();
    ready = 1'b0;
    send_word(rand_word(), 1'b1);
    idle(32);
    send_word(rand_word(), 1'b1);
    idle(32);
    // Third word completes while the full buffer is popped in the same cycle.
    w = rand_word();
    exp_q.push_back(w);
    send_bits(w, 63);
    ready = 1'b1;
    tick(1'b1, w[63]);
    ready = 1'b0;
    check_int("b2b_no_overflow", ovf_seen, 0);
    check_int("b2b_still_full", int'(valid), 1);
    ready = 1'b1;
    idle(32);
    check_int("b2b_no_overflow_end", ovf_seen, 0);
    check_int("b2b_drained", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid();
    clear_counts();
    ready = 1'b0;
    send_word(rand_word(), 1'b1);
    idle(32);
    check_int("rstmid_one_entry", int'(valid), 1);
    send_bits(rand_word(), 20);
    rst = 1'b1;
    #1;
    check_outputs_zero("rstmid_async_outputs");
    exp_q.delete();
    idle(2);
    check_outputs_zero("rstmid_held_outputs");
    rst = 1'b0;
    send_word(rand_word(), 1'b1);
    ready = 1'b1;
    idle(4);
    check_int("rstmid_drained", exp_q.size(), 0);
    check_int("rstmid_no_errors", frame_seen + gap_seen + ovf_seen, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    rx_active      = 1'b0;
    rxdatasb       = 1'b0;
    pattern_det_en = 1'b0;
    ready          = 1'b0;
    clear_counts();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_gap_err();
    test_frame_err();
    test_pattern();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
